// File: rtl/xor_accum_pkg.sv
// Shared types and constants for the XOR accumulator slice.
// Optional macro XOR_ACCUM_OVERFLOW_EN is consumed by xor_accum_unit.
package xor_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic MODE_XOR  = 1'b0;
    localparam logic MODE_XNOR = 1'b1;

endpackage

// File: rtl/xor_fold_word.sv
// Combinational WIDTH-bit bitwise XOR, one four-NAND XOR cell per bit.
module xor_fold_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic n1, n2, n3;
        assign n1   = ~(a[i] & b[i]);
        assign n2   = ~(a[i] & n1);
        assign n3   = ~(b[i] & n1);
        assign y[i] = ~(n2 & n3);
    end

endmodule

// File: rtl/xor_accum_unit.sv
// Per-frame XOR/XNOR checksum over a valid/ready word stream.
// Define XOR_ACCUM_OVERFLOW_EN to add the out_overflow result flag.
module xor_accum_unit
    import xor_accum_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    localparam int CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
`ifdef XOR_ACCUM_OVERFLOW_EN
    output logic             out_overflow,
`endif
    output logic             out_parity
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] fold;
    logic [CW-1:0]    count;
    logic             mode_q;
    logic             accept;
    logic             take;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    xor_fold_word #(.WIDTH(WIDTH)) u_fold (
        .a (acc),
        .b (in_data),
        .y (fold)
    );

    // Result fields are decoded from registers and forced to zero outside HOLD.
    always_comb begin
        out_data  = '0;
        out_count = '0;
        if (state == HOLD) begin
            out_data  = (mode_q == MODE_XNOR) ? ~acc : acc;
            out_count = count;
        end
        out_parity = ^out_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            count  <= '0;
            mode_q <= MODE_XOR;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc    <= in_data;
                    count  <= CW'(1);
                    mode_q <= mode;
                    state  <= in_last ? HOLD : ACCUM;
                end
                ACCUM: if (accept) begin
                    acc <= fold;
                    if (count != MAX_CNT) count <= count + CW'(1);
                    state <= in_last ? HOLD : ACCUM;
                end
                HOLD: if (take) begin
                    acc   <= '0;
                    count <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef XOR_ACCUM_OVERFLOW_EN
    logic ovf_q;

    // Only ACCUM can see a saturated count; IDLE always restarts at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (take) begin
            ovf_q <= 1'b0;
        end else if (state == ACCUM && accept && count == MAX_CNT) begin
            ovf_q <= 1'b1;
        end
    end

    assign out_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_xor_accum_unit.sv
// Randomised self-checking bench for xor_accum_unit against a frame-level model.
module tb_xor_accum_unit;

    localparam int W    = 8;
    localparam int MAXW = 4;
    localparam int CWT  = $clog2(MAXW + 1);

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           mode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [CWT-1:0] out_count;
    logic           out_parity;
`ifdef XOR_ACCUM_OVERFLOW_EN
    logic           out_overflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] fw[$];
    int           fg[$];
    logic         fmode;

    xor_accum_unit #(.WIDTH(W), .MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
`ifdef XOR_ACCUM_OVERFLOW_EN
        .out_overflow (out_overflow),
`endif
        .out_parity(out_parity)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_sum(input logic m);
        logic [W-1:0] x = '0;
        foreach (fw[i]) x = x ^ fw[i];
        return m ? ~x : x;
    endfunction

    function automatic logic [CWT-1:0] ref_count();
        return CWT'((fw.size() > MAXW) ? MAXW : fw.size());
    endfunction

    function automatic logic ref_ovf();
        return fw.size() > MAXW;
    endfunction

    // Presents fw[] with fg[] idle cycles before each beat; leaves the bench at the
    // falling edge after the last beat was accepted.
    task automatic send_frame();
        int guard;
        for (int i = 0; i < fw.size(); i++) begin
            for (int g = 0; g < fg[i]; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = W'($urandom);
                in_last  = 1'($urandom);
                mode     = 1'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = fw[i];
            in_last  = (i == fw.size() - 1);
            mode     = (i == 0) ? fmode : 1'($urandom);
            guard = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20) begin
                n_cmp++; n_err++;
                $display("FAIL ready_timeout: in_ready=%0b required=1", in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic set_frame(input int n, input logic [W-1:0] v0, input logic [W-1:0] v1,
                             input logic [W-1:0] v2, input logic m);
        logic [W-1:0] v[3];
        v[0] = v0; v[1] = v1; v[2] = v2;
        fw.delete(); fg.delete();
        for (int i = 0; i < n; i++) begin
            fw.push_back(v[i % 3]);
            fg.push_back(0);
        end
        fmode = m;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        mode = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready, out_data, out_count, out_parity} !== {1'b0, 1'b1, {W{1'b0}}, {CWT{1'b0}}, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: v=%0b r=%0b d=%h c=%0d p=%0b required v=0 r=1 d=00 c=0 p=0",
                     out_valid, in_ready, out_data, out_count, out_parity);
        end
`ifdef XOR_ACCUM_OVERFLOW_EN
        n_cmp++;
        if (out_overflow !== 1'b0) begin
            n_err++; $display("FAIL reset_ovf: got=%0b required=0", out_overflow);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        // two beats without last leave the unit in ACCUM
        @(negedge clk); in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b0; mode = 1'b0;
        @(negedge clk); in_data = 8'h0F;
        @(negedge clk); in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_count} !== {1'b0, 1'b1, {CWT{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_accum: v=%0b r=%0b c=%0d required v=0 r=1 c=0", out_valid, in_ready, out_count);
        end
        #1 reset = 1'b0;
        set_frame(1, 8'h11, 8'h00, 8'h00, 1'b0);
        send_frame();
        n_cmp++;
        if ({out_valid, out_data, out_count} !== {1'b1, 8'h11, CWT'(1)}) begin
            n_err++;
            $display("FAIL after_reset_frame: v=%0b d=%h c=%0d required v=1 d=11 c=1", out_valid, out_data, out_count);
        end
        // reset while holding a result drops it at once
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_data, out_count} !== {1'b0, 1'b1, {W{1'b0}}, {CWT{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_hold: v=%0b r=%0b d=%h c=%0d required v=0 r=1 d=00 c=0",
                     out_valid, in_ready, out_data, out_count);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_basic(input logic m, input logic [W-1:0] exp_d, input string nm);
        set_frame(3, 8'hA5, 8'h3C, 8'h0F, m);
        send_frame();
        out_ready = 1'b1;
        n_cmp++;
        if ({out_valid, out_data, out_count, out_parity} !== {1'b1, exp_d, CWT'(3), 1'b0}) begin
            n_err++;
            $display("FAIL %s_result: v=%0b d=%h c=%0d p=%0b required v=1 d=%h c=3 p=0",
                     nm, out_valid, out_data, out_count, out_parity, exp_d);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL %s_one_cycle: v=%0b r=%0b required v=0 r=1", nm, out_valid, in_ready);
        end
    endtask

    task automatic test_hold();
        set_frame(1, 8'h01, 8'h00, 8'h00, 1'b0);
        send_frame();
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({out_valid, in_ready, out_data, out_parity} !== {1'b1, 1'b0, 8'h01, 1'b1}) begin
                n_err++;
                $display("FAIL hold_c%0d: v=%0b r=%0b d=%h p=%0b required v=1 r=0 d=01 p=1",
                         c, out_valid, in_ready, out_data, out_parity);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL hold_take: v=%0b r=%0b required v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_gaps();
        set_frame(2, 8'h12, 8'h34, 8'h00, 1'b0);
        fg[0] = 1; fg[1] = 2;
        send_frame();
        out_ready = 1'b1;
        n_cmp++;
        if ({out_valid, out_data, out_count} !== {1'b1, 8'h26, CWT'(2)}) begin
            n_err++;
            $display("FAIL gaps: v=%0b d=%h c=%0d required v=1 d=26 c=2", out_valid, out_data, out_count);
        end
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        set_frame(6, 8'h01, 8'h01, 8'h01, 1'b0);
        send_frame();
        out_ready = 1'b1;
        n_cmp++;
        if ({out_valid, out_data, out_count} !== {1'b1, 8'h00, CWT'(MAXW)}) begin
            n_err++;
            $display("FAIL saturate: v=%0b d=%h c=%0d required v=1 d=00 c=%0d", out_valid, out_data, out_count, MAXW);
        end
`ifdef XOR_ACCUM_OVERFLOW_EN
        n_cmp++;
        if (out_overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_set: got=%0b required=1", out_overflow);
        end
`endif
        @(negedge clk); out_ready = 1'b0;
        set_frame(2, 8'h5A, 8'h0F, 8'h00, 1'b0);
        send_frame();
        out_ready = 1'b1;
        n_cmp++;
        if ({out_data, out_count} !== {8'h55, CWT'(2)}) begin
            n_err++; $display("FAIL post_sat: d=%h c=%0d required d=55 c=2", out_data, out_count);
        end
`ifdef XOR_ACCUM_OVERFLOW_EN
        n_cmp++;
        if (out_overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_clear: got=%0b required=0", out_overflow);
        end
`endif
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] exp_d;
        for (int f = 0; f < 40; f++) begin
            int n    = $urandom_range(1, 7);
            int hold = $urandom_range(0, 3);
            fw.delete(); fg.delete();
            for (int i = 0; i < n; i++) begin
                fw.push_back(W'($urandom));
                fg.push_back((f % 4 == 0) ? 0 : $urandom_range(0, 2));
            end
            fmode = 1'($urandom);
            exp_d = ref_sum(fmode);
            send_frame();
            for (int h = 0; h < hold; h++) begin
                n_cmp++;
                if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp_d}) begin
                    n_err++;
                    $display("FAIL rnd%0d_hold%0d: v=%0b r=%0b d=%h required v=1 r=0 d=%h",
                             f, h, out_valid, in_ready, out_data, exp_d);
                end
                @(negedge clk);
            end
            out_ready = 1'b1;
            n_cmp++;
            if ({out_valid, out_data, out_count, out_parity} !== {1'b1, exp_d, ref_count(), ^exp_d}) begin
                n_err++;
                $display("FAIL rnd%0d_result: v=%0b d=%h c=%0d p=%0b required v=1 d=%h c=%0d p=%0b",
                         f, out_valid, out_data, out_count, out_parity, exp_d, ref_count(), ^exp_d);
            end
`ifdef XOR_ACCUM_OVERFLOW_EN
            n_cmp++;
            if (out_overflow !== ref_ovf()) begin
                n_err++; $display("FAIL rnd%0d_ovf: got=%0b required=%0b", f, out_overflow, ref_ovf());
            end
`endif
            @(negedge clk);
            out_ready = 1'b0;
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_err++; $display("FAIL rnd%0d_bubble: v=%0b r=%0b required v=0 r=1", f, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_basic(1'b0, 8'h96, "xor");
        test_basic(1'b1, 8'h69, "xnor");
        test_hold();
        test_gaps();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
